// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the unified-memory arbiter and its helpers.
package mem_arb_pkg;

  typedef enum logic {IDLE, WAIT} arb_state_t;
  typedef enum logic {REQ_F, REQ_D} requester_t;

  localparam int MAX_MEM_LATENCY = 3;

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, on contention the one
// that did not win last time wins. Purely combinational.
module arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic       [1:0] req,        // bit 0 = REQ_F, bit 1 = REQ_D
  input  requester_t       last_grant,
  output logic       [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req[0] && req[1]) begin
      gnt = (last_grant == REQ_F) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data
// load/store; one access in flight, read data routed back to its owner.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int ADDR_BITS   = 7,
  parameter int MEM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 f_req,
  input  logic [ADDR_BITS-1:0] f_addr,
  output logic                 f_gnt,
  output logic                 f_rvalid,
  output logic [DATA_BITS-1:0] f_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_BITS-1:0] d_addr,
  input  logic [DATA_BITS-1:0] d_wdata,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  output logic [DATA_BITS-1:0] d_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > MAX_MEM_LATENCY) begin : g_bad_latency
    $error("mem_arbiter: MEM_LATENCY must be in 1..%0d", MAX_MEM_LATENCY);
  end

  localparam logic [1:0] LAT_INIT = 2'(MEM_LATENCY - 1);

  arb_state_t state_reg;
  requester_t owner_reg;
  requester_t last_grant_reg;
  logic [1:0] lat_cnt_reg;

  logic [1:0] pick;
  logic       issue_ok;
  logic       rvalid_now;

  arb_rr_pick u_pick (
    .req       ({d_req, f_req}),
    .last_grant(last_grant_reg),
    .gnt       (pick)
  );

  // Reset low masks every strobe in the same cycle, not just the next one.
  assign issue_ok   = reset && (state_reg == IDLE);
  assign rvalid_now = reset && (state_reg == WAIT) && (lat_cnt_reg == 2'd0);

  assign f_gnt     = issue_ok && pick[0];
  assign d_gnt     = issue_ok && pick[1];
  assign mem_en    = f_gnt || d_gnt;
  assign mem_we    = d_gnt && d_we;
  assign mem_addr  = d_gnt ? d_addr : f_addr;
  assign mem_wdata = d_wdata;

  assign f_rvalid = rvalid_now && (owner_reg == REQ_F);
  assign d_rvalid = rvalid_now && (owner_reg == REQ_D);
  assign f_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      owner_reg      <= REQ_F;
      last_grant_reg <= REQ_D;
      lat_cnt_reg    <= 2'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (mem_en) begin
            last_grant_reg <= d_gnt ? REQ_D : REQ_F;
            // Writes complete in the grant cycle, so only reads occupy the port.
            if (!mem_we) begin
              owner_reg   <= d_gnt ? REQ_D : REQ_F;
              lat_cnt_reg <= LAT_INIT;
              state_reg   <= WAIT;
            end
          end
        end
        WAIT: begin
          if (lat_cnt_reg == 2'd0) begin
            state_reg <= IDLE;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter at MEM_LATENCY 1 and 3, checked against a
// timestamp-based reference model and a read-response scoreboard.
module tb_mem_arbiter;

  localparam int DB = 8;
  localparam int AB = 7;

  typedef struct {
    bit          is_d;
    logic [7:0]  data;
    int          addr;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  logic          f_req     [2];
  logic [AB-1:0] f_addr    [2];
  logic          f_gnt     [2];
  logic          f_rvalid  [2];
  logic [DB-1:0] f_rdata   [2];
  logic          d_req     [2];
  logic          d_we      [2];
  logic [AB-1:0] d_addr    [2];
  logic [DB-1:0] d_wdata   [2];
  logic          d_gnt     [2];
  logic          d_rvalid  [2];
  logic [DB-1:0] d_rdata   [2];
  logic          mem_en    [2];
  logic          mem_we    [2];
  logic [AB-1:0] mem_addr  [2];
  logic [DB-1:0] mem_wdata [2];
  logic [DB-1:0] mem_rdata [2];

  int tests;
  int fails;
  int cyc;
  bit done;
  bit final_done;

  // Reference model state: next cycle an issue may happen, who won last,
  // an independent memory image, and the expected read responses.
  int         next_issue [2];
  bit         last_d     [2];
  logic [7:0] ref_mem    [2][128];
  bit         ref_loaded;
  exp_t       sb         [2][$];
  bit         seen_f     [2];
  bit         seen_d     [2];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int L = (gi == 0) ? 1 : 3;
    logic [DB-1:0] mem_arr [128];
    logic [DB-1:0] rd_pipe [1:3];
    bit            loaded;

    mem_arbiter #(.DATA_BITS(DB), .ADDR_BITS(AB), .MEM_LATENCY(L)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .f_req    (f_req[gi]),
      .f_addr   (f_addr[gi]),
      .f_gnt    (f_gnt[gi]),
      .f_rvalid (f_rvalid[gi]),
      .f_rdata  (f_rdata[gi]),
      .d_req    (d_req[gi]),
      .d_we     (d_we[gi]),
      .d_addr   (d_addr[gi]),
      .d_wdata  (d_wdata[gi]),
      .d_gnt    (d_gnt[gi]),
      .d_rvalid (d_rvalid[gi]),
      .d_rdata  (d_rdata[gi]),
      .mem_en   (mem_en[gi]),
      .mem_we   (mem_we[gi]),
      .mem_addr (mem_addr[gi]),
      .mem_wdata(mem_wdata[gi]),
      .mem_rdata(mem_rdata[gi])
    );

    assign mem_rdata[gi] = rd_pipe[L];

    // Memory with fixed read latency; garbage on the bus when no read is due.
    always @(posedge clk) begin
      if (!loaded) begin
        for (int k = 0; k < 128; k++) mem_arr[k] <= 8'(k);
        loaded <= 1'b1;
      end else if (mem_en[gi] && mem_we[gi]) begin
        mem_arr[mem_addr[gi]] <= mem_wdata[gi];
      end
      rd_pipe[1] <= (mem_en[gi] && !mem_we[gi]) ? mem_arr[mem_addr[gi]] : 8'($urandom);
      rd_pipe[2] <= rd_pipe[1];
      rd_pipe[3] <= rd_pipe[2];
    end
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input int i, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s inst%0d cyc %0d: got %0h expected %0h", nm, i, cyc, got, exp);
    end
  endtask

  // Model step and scoreboard monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    if (!ref_loaded) begin
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < 128; k++) ref_mem[i][k] = 8'(k);
      ref_loaded = 1'b1;
    end
    if (done && !final_done) begin
      for (int i = 0; i < 2; i++) chk("drain_left", i, sb[i].size(), 0);
      final_done = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      bit   ef, ed, wr;
      int   ea;
      exp_t e;
      ef = 1'b0; ed = 1'b0; wr = 1'b0; ea = 0;
      seen_f[i] = f_gnt[i];
      seen_d[i] = d_gnt[i];

      if (!reset) begin
        next_issue[i] = cyc + 1;
        last_d[i]     = 1'b1;
        sb[i].delete();
      end else if (cyc >= next_issue[i] && (f_req[i] || d_req[i])) begin
        ed = d_req[i] && (!f_req[i] || !last_d[i]);
        ef = !ed;
        last_d[i] = ed;
        ea = ed ? int'(d_addr[i]) : int'(f_addr[i]);
        wr = ed && d_we[i];
        if (wr) begin
          ref_mem[i][ea] = d_wdata[i];
          next_issue[i]  = cyc + 1;
          $display("[TB] inst%0d cyc %0d write addr=%02h data=%02h", i, cyc, ea, d_wdata[i]);
        end else begin
          next_issue[i] = cyc + lat_of(i) + 1;
          e.is_d = ed;
          e.data = ref_mem[i][ea];
          e.addr = ea;
          e.due  = cyc + lat_of(i);
          sb[i].push_back(e);
        end
      end

      chk("grant", i, {f_gnt[i], d_gnt[i]}, {ef, ed});
      chk("mem_en", i, mem_en[i], ef || ed);
      chk("mem_we", i, mem_we[i], wr);
      if (ef || ed) begin
        chk("mem_addr", i, mem_addr[i], ea);
        if (wr) chk("mem_wdata", i, mem_wdata[i], d_wdata[i]);
      end

      if (f_rvalid[i] || d_rvalid[i]) begin
        if (sb[i].size() == 0) begin
          chk("unexpected_rvalid", i, {f_rvalid[i], d_rvalid[i]}, 0);
        end else begin
          e = sb[i].pop_front();
          chk("rvalid_owner", i, {f_rvalid[i], d_rvalid[i]}, {!e.is_d, e.is_d});
          chk("rvalid_cycle", i, cyc, e.due);
          chk("rdata", i, e.is_d ? d_rdata[i] : f_rdata[i], e.data);
          $display("[TB] inst%0d cyc %0d read %s addr=%02h data=%02h", i, cyc,
                   e.is_d ? "D" : "F", e.addr, e.is_d ? d_rdata[i] : f_rdata[i]);
        end
      end else if (sb[i].size() > 0 && sb[i][0].due <= cyc) begin
        e = sb[i].pop_front();
        chk("missing_rvalid", i, 0, 1);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_all(input logic rst, input logic fr, input int fa,
                         input logic dr, input logic we, input int da, input int wd);
    reset = rst;
    for (int i = 0; i < 2; i++) begin
      f_req[i]   = fr;
      f_addr[i]  = AB'(fa);
      d_req[i]   = dr;
      d_we[i]    = we;
      d_addr[i]  = AB'(da);
      d_wdata[i] = DB'(wd);
    end
  endtask

  initial begin
    // Reset held with a pending fetch, then released.
    set_all(0, 1, 'h00, 0, 0, 0, 0);    step(3);
    set_all(1, 1, 'h00, 0, 0, 0, 0);    step(1);
    set_all(1, 0, 0, 0, 0, 0, 0);       step(4);
    // Single fetch.
    set_all(1, 1, 'h25, 0, 0, 0, 0);    step(1);
    set_all(1, 0, 0, 0, 0, 0, 0);       step(4);
    // Contention straight out of reset, held to show alternation.
    set_all(0, 0, 0, 0, 0, 0, 0);       step(1);
    set_all(1, 1, 'h05, 1, 0, 'h09, 0); step(12);
    set_all(1, 0, 0, 0, 0, 0, 0);       step(5);
    // Back-to-back writes, then read one back.
    set_all(1, 0, 0, 1, 1, 'h03, 'hAA); step(1);
    set_all(1, 0, 0, 1, 1, 'h04, 'hBB); step(1);
    set_all(1, 0, 0, 0, 0, 0, 0);       step(2);
    set_all(1, 1, 'h03, 0, 0, 0, 0);    step(1);
    set_all(1, 0, 0, 0, 0, 0, 0);       step(5);
    // Data read while a fetch waits out the latency.
    set_all(1, 1, 'h01, 1, 0, 'h40, 0); step(1);
    set_all(1, 1, 'h01, 0, 0, 0, 0);    step(5);
    set_all(1, 0, 0, 0, 0, 0, 0);       step(6);
    // Reset one cycle after a read grant abandons it.
    set_all(1, 0, 0, 1, 0, 'h41, 0);    step(1);
    set_all(0, 0, 0, 0, 0, 0, 0);       step(2);
    set_all(1, 1, 'h02, 0, 0, 0, 0);    step(1);
    set_all(1, 0, 0, 0, 0, 0, 0);       step(6);

    // Random traffic; each requester holds until granted or occasionally gives up.
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(199) != 0);
      for (int i = 0; i < 2; i++) begin
        if (f_req[i] && !seen_f[i]) begin
          if ($urandom_range(15) == 0) f_req[i] = 1'b0;
        end else begin
          f_req[i]  = ($urandom_range(2) != 0);
          f_addr[i] = AB'($urandom_range(15));
        end
        if (d_req[i] && !seen_d[i]) begin
          if ($urandom_range(15) == 0) d_req[i] = 1'b0;
        end else begin
          d_req[i]   = ($urandom_range(2) != 0);
          d_we[i]    = ($urandom_range(1) != 0);
          d_addr[i]  = AB'($urandom_range(15));
          d_wdata[i] = DB'($urandom);
        end
      end
      step(1);
    end

    set_all(1, 0, 0, 0, 0, 0, 0);
    step(10);
    done = 1'b1;
    step(3);
    if (!final_done) begin
      fails++;
      $display("FAIL drain_check: got not_run expected run");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported unified memory of the execution unit between two requesters: instruction fetch (read-only) and data load/store (read/write).
- Sits between exec_unit's fetch and load/store logic and the memory array.
- Round-robin arbitration on contention, with a configurable fixed read latency.
- Guarantees at most one memory access in flight and routes read data back to the owner.

Parameters:
- DATA_BITS, 8, memory word width.
- ADDR_BITS, 7, memory address width (128 words).
- MEM_LATENCY, 1, cycles from read issue to valid mem_rdata; legal range 1..3.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-low reset.
- f_req  in  1  fetch read request; held until f_gnt.
- f_addr  in  ADDR_BITS  fetch address.
- f_gnt  out  1  fetch request issued to memory this cycle.
- f_rvalid  out  1  f_rdata valid (1-cycle pulse).
- f_rdata  out  DATA_BITS  fetch read data.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1=write, 0=read.
- d_addr  in  ADDR_BITS  data address.
- d_wdata  in  DATA_BITS  write data.
- d_gnt  out  1  data request issued this cycle.
- d_rvalid  out  1  d_rdata valid (1-cycle pulse, reads only).
- d_rdata  out  DATA_BITS  data read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_BITS  memory address.
- mem_wdata  out  DATA_BITS  memory write data.
- mem_rdata  in  DATA_BITS  memory read data, valid MEM_LATENCY cycles after issue.

Behaviour:
- State registers: state {IDLE, WAIT}, owner {F, D}, last_grant {F, D}, lat_cnt (2 bits).
- While reset=0 at a clock edge: state=IDLE, last_grant=D, lat_cnt=0. During any cycle with reset=0, all gnt/rvalid/mem_en/mem_we outputs are forced to 0.
- Data outputs (mem_addr, mem_wdata, rdata) are don't-care when their strobes are 0. f_rdata and d_rdata are driven from mem_rdata.
- IDLE, no req: no outputs asserted.
- IDLE, exactly one req: grant it combinationally in the same cycle.
- IDLE, both req: grant the requester that is not last_grant.
- Grant cycle (T):
  - gnt_x=1, mem_en=1.
  - mem_addr = winner address.
  - mem_we = d_we if D, else 0.
  - mem_wdata = d_wdata.
  - last_grant <= winner.
- Write grant: state stays IDLE; a new grant is possible at T+1 (back-to-back writes).
- Read grant: owner <= winner, lat_cnt <= MEM_LATENCY-1, state <= WAIT.
- WAIT:
  - No grants, mem_en=0.
  - lat_cnt decrements each cycle until 0.
  - In the cycle where lat_cnt==0 (cycle T+MEM_LATENCY), assert rvalid of owner for 1 cycle, then state <= IDLE.
  - Next earliest issue is T+MEM_LATENCY+1. With MEM_LATENCY=1, the read throughput is 1 per 2 cycles.
- Requester must hold req/addr/we/wdata stable until gnt; a req dropped before gnt is simply not served.
- A requester whose req stays high after gnt is treated as a new request.
- Fairness: under continuous contention, grants strictly alternate F,D,F,D...
- Reset asserted while in WAIT: the outstanding read is abandoned, no rvalid is ever produced for it, and the next cycle after reset release is IDLE.
- MEM_LATENCY outside 1..3 is a compile-time error via elaboration check.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum arb_state_t {IDLE, WAIT}.
  - typedef enum requester_t {REQ_F, REQ_D}.
  - localparam MAX_MEM_LATENCY=3.
- Sub-module arb_rr_pick:
  - Inputs: two req bits and last_grant.
  - Outputs: one-hot grant.
  - Pure combinational, reused by later multi-port arbiters.

Test Plan (memory preloaded mem[i]=i, MEM_LATENCY=1 unless noted):
- Reset held low 3 cycles with f_req=1: f_gnt=0, mem_en=0 throughout. First cycle after release: f_gnt=1, mem_addr=0.
- Single fetch read at f_addr=0x25: f_gnt=1 in cycle T; f_rvalid=1 with f_rdata=0x25 in T+1; no pulse at T+2.
- Simultaneous f_req (addr 5) and d_req read (addr 9) right after reset:
  - Fetch is granted first, f_rdata=5 at T+1.
  - d_gnt at T+2, d_rdata=9 at T+3.
  - Holding both reqs afterwards gives alternating grants F,D,F,D.
- Data writes 0xAA to addr 3, then 0xBB to addr 4, on consecutive cycles: d_gnt at T and T+1, mem_we=1 both cycles, no d_rvalid. A later fetch of addr 3 returns 0xAA.
- MEM_LATENCY=3, data read at addr 0x40 issued at T: no grant to a pending f_req during T+1..T+3; d_rvalid=1 with d_rdata=0x40 at T+3; f_gnt at T+4.
- Reset asserted at T+1 after a read grant at T (MEM_LATENCY=3): no rvalid is ever produced for that read, and after release the arbiter grants normally from IDLE.
